// File: rtl/axi4_burst_to_axi4_stream.sv
// axi4_burst_to_axi4_stream
// Fetches one packet from memory with AXI4 INCR read bursts (at most one
// burst outstanding) and forwards the read data beat-for-beat, with no
// buffering, as a single AXI4-Stream packet.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   addr_i, pkt_size_i        packet byte address and size in bytes
//   done_o                    one-cycle pulse after the final beat
//   err_o                     sticky read error, cleared by the next request
//   burst_ar*/burst_r*        AXI4 read address / read data channels
//   burst_aw*/burst_w*/bready AXI4 write channels, permanently idle
//   pkt_t*                    AXI4-Stream output packet
//
// Optional feature macro: AXI_4K_SPLIT_EN -- when defined, bursts are also
// trimmed so that none crosses a 4 KB address boundary.
`timescale 1ns/1ps
module axi4_burst_to_axi4_stream #(
    parameter int DATA_WIDTH         = 64,
    parameter int ADDR_WIDTH         = 32,
    parameter int ID_WIDTH           = 1,
    parameter int AWUSER_WIDTH       = 1,
    parameter int WUSER_WIDTH        = 1,
    parameter int ARUSER_WIDTH       = 1,
    parameter int MAX_PKT_SIZE_B     = 2048,
    parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_i,
    output logic                          done_o,
    output logic                          err_o,
    // read address channel
    output logic [ID_WIDTH-1:0]           burst_arid_o,
    output logic [ADDR_WIDTH-1:0]         burst_araddr_o,
    output logic [7:0]                    burst_arlen_o,
    output logic [2:0]                    burst_arsize_o,
    output logic [1:0]                    burst_arburst_o,
    output logic                          burst_arlock_o,
    output logic [3:0]                    burst_arcache_o,
    output logic [2:0]                    burst_arprot_o,
    output logic [3:0]                    burst_arqos_o,
    output logic [3:0]                    burst_arregion_o,
    output logic [ARUSER_WIDTH-1:0]       burst_aruser_o,
    output logic                          burst_arvalid_o,
    input  logic                          burst_arready_i,
    // read data channel
    input  logic [DATA_WIDTH-1:0]         burst_rdata_i,
    input  logic [1:0]                    burst_rresp_i,
    input  logic                          burst_rlast_i,
    input  logic                          burst_rvalid_i,
    output logic                          burst_rready_o,
    // write channels (unused)
    output logic [ID_WIDTH-1:0]           burst_awid_o,
    output logic [ADDR_WIDTH-1:0]         burst_awaddr_o,
    output logic [7:0]                    burst_awlen_o,
    output logic [2:0]                    burst_awsize_o,
    output logic [1:0]                    burst_awburst_o,
    output logic                          burst_awlock_o,
    output logic [3:0]                    burst_awcache_o,
    output logic [2:0]                    burst_awprot_o,
    output logic [3:0]                    burst_awqos_o,
    output logic [3:0]                    burst_awregion_o,
    output logic [AWUSER_WIDTH-1:0]       burst_awuser_o,
    output logic                          burst_awvalid_o,
    output logic [DATA_WIDTH-1:0]         burst_wdata_o,
    output logic [DATA_WIDTH/8-1:0]       burst_wstrb_o,
    output logic                          burst_wlast_o,
    output logic [WUSER_WIDTH-1:0]        burst_wuser_o,
    output logic                          burst_wvalid_o,
    output logic                          burst_bready_o,
    // output stream
    output logic [DATA_WIDTH-1:0]         pkt_tdata_o,
    output logic [DATA_WIDTH/8-1:0]       pkt_tkeep_o,
    output logic [DATA_WIDTH/8-1:0]       pkt_tstrb_o,
    output logic                          pkt_tlast_o,
    output logic                          pkt_tuser_o,
    output logic                          pkt_tvalid_o,
    input  logic                          pkt_tready_i
);

    localparam int DATA_WIDTH_B = DATA_WIDTH / 8;
    localparam int WORD_SHIFT   = $clog2(DATA_WIDTH_B);
    localparam int WORDS_W      = MAX_PKT_SIZE_WIDTH + 1 - WORD_SHIFT;
    // wide enough for word counts and for the 4 KB page word count
    localparam int CNT_W        = (WORDS_W > 13) ? WORDS_W + 1 : 14;

    typedef enum logic [1:0] {IDLE_S, CALC_BURST_S, ADDR_S, DATA_S} state_t;

    state_t                    r_state, w_state_next;
    logic [WORDS_W-1:0]        r_words_left;
    logic [7:0]                r_burst_left;
    logic [7:0]                r_arlen;
    logic [ADDR_WIDTH-1:0]     r_cur_addr;
    logic [ADDR_WIDTH-1:0]     r_araddr;
    logic [DATA_WIDTH_B-1:0]   r_last_keep;
    logic                      r_first;
    logic                      r_done;
    logic                      r_err;

    logic                      w_req_ready, w_arvalid, w_rready, w_tvalid;
    logic                      w_req_hs, w_beat, w_last_word, w_rd_err;
    logic [MAX_PKT_SIZE_WIDTH:0] w_size_round;
    logic [WORDS_W-1:0]        w_words;
    logic [WORD_SHIFT-1:0]     w_rem;
    logic [DATA_WIDTH_B-1:0]   w_keep;
    logic [ADDR_WIDTH-1:0]     w_addr_aligned;
    logic [CNT_W-1:0]          w_burst_words;
    logic [7:0]                w_arlen;

    // ceil(size / bytes-per-word), one extra bit so the rounding cannot wrap
    assign w_size_round   = {1'b0, pkt_size_i} + (MAX_PKT_SIZE_WIDTH+1)'(DATA_WIDTH_B - 1);
    assign w_words        = w_size_round[MAX_PKT_SIZE_WIDTH:WORD_SHIFT];
    assign w_rem          = pkt_size_i[WORD_SHIFT-1:0];
    assign w_addr_aligned = addr_i & ~ADDR_WIDTH'(DATA_WIDTH_B - 1);

    // final-beat byte mask: low r bytes valid, or all bytes when r == 0
    for (genvar gi = 0; gi < DATA_WIDTH_B; gi++) begin : g_keep
        assign w_keep[gi] = (w_rem == '0) || (w_rem > WORD_SHIFT'(gi));
    end

`ifdef AXI_4K_SPLIT_EN
    logic [CNT_W-1:0] w_page_words;
    assign w_page_words = (CNT_W'(4096) - CNT_W'(r_cur_addr[11:0])) >> WORD_SHIFT;
`endif

    always_comb begin
        w_burst_words = (CNT_W'(r_words_left) > CNT_W'(256)) ? CNT_W'(256) : CNT_W'(r_words_left);
`ifdef AXI_4K_SPLIT_EN
        if (w_page_words < w_burst_words) begin
            w_burst_words = w_page_words;
        end
`endif
    end
    assign w_arlen = 8'(w_burst_words - CNT_W'(1));

    assign w_last_word = (r_words_left == WORDS_W'(1));
    assign w_req_hs    = req_valid_i && w_req_ready;
    assign w_rd_err    = (burst_rresp_i != 2'b00) ||
                         ( burst_rlast_i && (r_burst_left != 8'd0)) ||
                         (!burst_rlast_i && (r_burst_left == 8'd0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE_S;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_tvalid     = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            IDLE_S: begin
                w_req_ready = 1'b1;
                // a zero-length packet never leaves IDLE; done pulses directly
                if (w_req_hs && (w_words != '0)) begin
                    w_state_next = CALC_BURST_S;
                end
            end
            CALC_BURST_S: begin
                w_state_next = ADDR_S;
            end
            ADDR_S: begin
                w_arvalid = 1'b1;
                if (burst_arready_i) begin
                    w_state_next = DATA_S;
                end
            end
            DATA_S: begin
                w_tvalid = burst_rvalid_i;
                w_rready = pkt_tready_i;
                w_beat   = burst_rvalid_i && pkt_tready_i;
                // burst length follows the internal count, not rlast
                if (w_beat && (r_burst_left == 8'd0)) begin
                    w_state_next = (r_words_left > WORDS_W'(1)) ? CALC_BURST_S : IDLE_S;
                end
            end
            default: w_state_next = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_words_left <= '0;
            r_burst_left <= '0;
            r_arlen      <= '0;
            r_cur_addr   <= '0;
            r_araddr     <= '0;
            r_last_keep  <= '0;
            r_first      <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE_S: begin
                    if (w_req_hs) begin
                        r_words_left <= w_words;
                        r_cur_addr   <= w_addr_aligned;
                        r_last_keep  <= w_keep;
                        r_first      <= 1'b1;
                        r_err        <= 1'b0;
                        r_done       <= (w_words == '0);
                    end
                end
                CALC_BURST_S: begin
                    r_arlen      <= w_arlen;
                    r_araddr     <= r_cur_addr;
                    r_burst_left <= w_arlen;
                end
                DATA_S: begin
                    if (w_beat) begin
                        r_burst_left <= r_burst_left - 8'd1;
                        r_words_left <= r_words_left - WORDS_W'(1);
                        r_cur_addr   <= r_cur_addr + ADDR_WIDTH'(DATA_WIDTH_B);
                        r_first      <= 1'b0;
                        if (w_rd_err) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_word) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o      = w_req_ready;
    assign done_o           = r_done;
    assign err_o            = r_err;

    assign burst_arid_o     = '0;
    assign burst_araddr_o   = r_araddr;
    assign burst_arlen_o    = r_arlen;
    assign burst_arsize_o   = 3'(WORD_SHIFT);
    assign burst_arburst_o  = 2'b01;
    assign burst_arlock_o   = 1'b0;
    assign burst_arcache_o  = '0;
    assign burst_arprot_o   = '0;
    assign burst_arqos_o    = '0;
    assign burst_arregion_o = '0;
    assign burst_aruser_o   = '0;
    assign burst_arvalid_o  = w_arvalid;
    assign burst_rready_o   = w_rready;

    assign burst_awid_o     = '0;
    assign burst_awaddr_o   = '0;
    assign burst_awlen_o    = '0;
    assign burst_awsize_o   = '0;
    assign burst_awburst_o  = '0;
    assign burst_awlock_o   = 1'b0;
    assign burst_awcache_o  = '0;
    assign burst_awprot_o   = '0;
    assign burst_awqos_o    = '0;
    assign burst_awregion_o = '0;
    assign burst_awuser_o   = '0;
    assign burst_awvalid_o  = 1'b0;
    assign burst_wdata_o    = '0;
    assign burst_wstrb_o    = '0;
    assign burst_wlast_o    = 1'b0;
    assign burst_wuser_o    = '0;
    assign burst_wvalid_o   = 1'b0;
    assign burst_bready_o   = 1'b1;

    assign pkt_tdata_o      = burst_rdata_i;
    assign pkt_tkeep_o      = w_last_word ? r_last_keep : '1;
    assign pkt_tstrb_o      = w_last_word ? r_last_keep : '1;
    assign pkt_tlast_o      = (r_state == DATA_S) && w_last_word;
    assign pkt_tuser_o      = r_first;
    assign pkt_tvalid_o     = w_tvalid;

endmodule
